// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with whole-scan debounce; drives one active-low column at a time
// and reports the committed key as hexValue/nokey with a key_valid pulse on each new key.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] hexValue,
    output logic       nokey,
    output logic       key_valid
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_SINGLE = 2'd1, CLS_MULTI = 2'd2} cls_e;

    logic [3:0]        row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [3:0]        col_q, col_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [15:0]       acc_q, acc_d;
    cls_e              cand_cls_q, cand_cls_d;
    logic [3:0]        cand_code_q, cand_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    cls_e              pend_cls_q, pend_cls_d;
    logic [3:0]        pend_code_q, pend_code_d;
    logic [3:0]        hex_q, hex_d;
    logic              nokey_q, nokey_d;
    logic              kv_q, kv_d;

    logic              slot_end, scan_end, same, commit;
    logic [15:0]       cur_bits, scan_bits;
    logic [4:0]        ones;
    cls_e              res_cls;
    logic [3:0]        res_code, raw_code;
    logic [CNT_W-1:0]  cnt_next;

    // Position index is {row, column}
    function automatic logic [3:0] key_code(input logic [3:0] pos);
        case (pos)
            4'd0:  return 4'h1;
            4'd1:  return 4'h2;
            4'd2:  return 4'h3;
            4'd3:  return 4'hA;
            4'd4:  return 4'h4;
            4'd5:  return 4'h5;
            4'd6:  return 4'h6;
            4'd7:  return 4'hB;
            4'd8:  return 4'h7;
            4'd9:  return 4'h8;
            4'd10: return 4'h9;
            4'd11: return 4'hC;
            4'd12: return 4'hE;
            4'd13: return 4'h0;
            4'd14: return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    always_comb begin
        slot_end = (slot_q == SLOT_LAST);
        scan_end = slot_end && (col_idx_q == 2'd3);

        cur_bits = '0;
        for (int r = 0; r < 4; r++) begin
            cur_bits[{2'(r), col_idx_q}] = ~row_s2_q[r];
        end
        scan_bits = acc_q | cur_bits;

        ones     = 5'd0;
        raw_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (scan_bits[i]) begin
                ones     = ones + 5'd1;
                raw_code = key_code(4'(i));
            end
        end
        if (ones == 5'd0) begin
            res_cls  = CLS_NONE;
            res_code = 4'h0;
        end else if (ones == 5'd1) begin
            res_cls  = CLS_SINGLE;
            res_code = raw_code;
        end else begin
            res_cls  = CLS_MULTI;
            res_code = 4'h0;
        end

        same     = (res_cls == cand_cls_q) && (res_code == cand_code_q);
        cnt_next = !same ? CNT_W'(1) : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // A saturated counter that stays saturated is a held state, not a fresh commit
        commit   = scan_end && (cnt_next == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
    end

    always_comb begin
        row_s1_d    = row;
        row_s2_d    = row_s1_q;
        slot_d      = slot_end ? '0 : slot_q + SLOT_W'(1);
        col_d       = slot_end ? {col_q[2:0], col_q[3]} : col_q;
        col_idx_d   = slot_end ? col_idx_q + 2'd1 : col_idx_q;
        acc_d       = slot_end ? (scan_end ? 16'h0 : scan_bits) : acc_q;
        cand_cls_d  = scan_end ? res_cls : cand_cls_q;
        cand_code_d = scan_end ? res_code : cand_code_q;
        cnt_d       = scan_end ? cnt_next : cnt_q;
        pend_d      = commit;
        pend_cls_d  = res_cls;
        pend_code_d = res_code;

        hex_d   = hex_q;
        nokey_d = nokey_q;
        kv_d    = 1'b0;
        if (pend_q) begin
            if (pend_cls_q == CLS_SINGLE) begin
                hex_d   = pend_code_q;
                nokey_d = 1'b0;
                kv_d    = nokey_q || (hex_q != pend_code_q);
            end else if (pend_cls_q == CLS_NONE) begin
                nokey_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            slot_q      <= '0;
            col_q       <= 4'b1110;
            col_idx_q   <= 2'd0;
            acc_q       <= 16'h0;
            cand_cls_q  <= CLS_NONE;
            cand_code_q <= 4'h0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_cls_q  <= CLS_NONE;
            pend_code_q <= 4'h0;
            hex_q       <= 4'h0;
            nokey_q     <= 1'b1;
            kv_q        <= 1'b0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            slot_q      <= slot_d;
            col_q       <= col_d;
            col_idx_q   <= col_idx_d;
            acc_q       <= acc_d;
            cand_cls_q  <= cand_cls_d;
            cand_code_q <= cand_code_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_cls_q  <= pend_cls_d;
            pend_code_q <= pend_code_d;
            hex_q       <= hex_d;
            nokey_q     <= nokey_d;
            kv_q        <= kv_d;
        end
    end

    assign col       = col_q;
    assign hexValue  = hex_q;
    assign nokey     = nokey_q;
    assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a keypad model and a scoreboard of expected key codes.
module tb_keypad_scan_4x4;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] hexValue;
    logic       nokey;
    logic       key_valid;

    logic [15:0] pressed;
    logic [3:0]  sb[$];
    logic [3:0]  exp_code;
    int          checks;
    int          errors;
    int          p;

    keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .hexValue(hexValue), .nokey(nokey), .key_valid(key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to position t (clocks since reset release); every key_valid pulse is scored
    task automatic goto_p(input int t);
        while (p < t) begin
            @(posedge clk);
            #1;
            p++;
            if (key_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_pulse: observed hexValue=%h at p=%0d expected no pulse", hexValue, p);
                end else begin
                    exp_code = sb.pop_front();
                    assert (hexValue === exp_code) else begin
                        errors++;
                        $error("FAIL pulse_code: observed=%h expected=%h", hexValue, exp_code);
                    end
                end
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        p       = 0;
        pressed = 16'h0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and column rotation
        check4("rst_col", col, 4'b1110);
        check1("rst_nokey", nokey, 1'b1);
        check4("rst_hex", hexValue, 4'h0);
        check1("rst_kv", key_valid, 1'b0);
        goto_p(4);  check4("col_c1", col, 4'b1101);
        goto_p(8);  check4("col_c2", col, 4'b1011);
        goto_p(12); check4("col_c3", col, 4'b0111);
        goto_p(16); check4("col_c0", col, 4'b1110);

        // Single press of 5
        pressed = 16'h1 << 5;
        sb.push_back(4'h5);
        goto_p(64); check1("k5_pre_nokey", nokey, 1'b1);
        goto_p(65);
        check4("k5_hex", hexValue, 4'h5);
        check1("k5_nokey", nokey, 1'b0);
        check1("k5_kv", key_valid, 1'b1);
        goto_p(66); check1("k5_kv_low", key_valid, 1'b0);
        goto_p(240);
        check4("k5_held_hex", hexValue, 4'h5);
        check1("k5_held_nokey", nokey, 1'b0);

        // Bounce on A: off/on alternating for five scans, then stable
        for (int k = 0; k < 5; k++) begin
            goto_p(240 + 16*k);
            pressed = (k % 2 == 1) ? (16'h1 << 3) : 16'h0;
        end
        goto_p(320);
        check4("bounce_hex", hexValue, 4'h5);
        check1("bounce_nokey", nokey, 1'b0);
        pressed = 16'h1 << 3;
        sb.push_back(4'hA);
        goto_p(368); check4("kA_pre_hex", hexValue, 4'h5);
        goto_p(369);
        check4("kA_hex", hexValue, 4'hA);
        check1("kA_kv", key_valid, 1'b1);

        // Release A, then 3 and a direct change to D
        goto_p(384); pressed = 16'h0;
        goto_p(432); check1("relA_pre_nokey", nokey, 1'b0);
        goto_p(433);
        check1("relA_nokey", nokey, 1'b1);
        check4("relA_hex", hexValue, 4'hA);
        check1("relA_kv", key_valid, 1'b0);
        goto_p(448); pressed = 16'h1 << 2; sb.push_back(4'h3);
        goto_p(497);
        check4("k3_hex", hexValue, 4'h3);
        check1("k3_nokey", nokey, 1'b0);
        goto_p(512); pressed = 16'h1 << 15; sb.push_back(4'hD);
        goto_p(560);
        check4("kD_pre_hex", hexValue, 4'h3);
        check1("kD_pre_nokey", nokey, 1'b0);
        goto_p(561);
        check4("kD_hex", hexValue, 4'hD);
        check1("kD_nokey", nokey, 1'b0);
        check1("kD_kv", key_valid, 1'b1);

        // Multi-key from the committed NONE state
        goto_p(576); pressed = 16'h0;
        goto_p(625); check1("relD_nokey", nokey, 1'b1);
        goto_p(640); pressed = 16'h0003;
        goto_p(800);
        check1("multi_nokey", nokey, 1'b1);
        check4("multi_hex", hexValue, 4'hD);
        pressed = 16'h0001;
        sb.push_back(4'h1);
        goto_p(848); check1("k1_pre_nokey", nokey, 1'b1);
        goto_p(849);
        check4("k1_hex", hexValue, 4'h1);
        check1("k1_nokey", nokey, 1'b0);

        // Reset while 8 is partially debounced
        goto_p(864); pressed = 16'h1 << 9;
        goto_p(885);
        rst = 1'b1;
        goto_p(886);
        rst = 1'b0;
        p = 0;
        check4("mid_rst_col", col, 4'b1110);
        check4("mid_rst_hex", hexValue, 4'h0);
        check1("mid_rst_nokey", nokey, 1'b1);
        check1("mid_rst_kv", key_valid, 1'b0);
        sb.push_back(4'h8);
        goto_p(4);  check4("mid_rst_col_step", col, 4'b1101);
        goto_p(48); check1("k8_pre_nokey", nokey, 1'b1);
        goto_p(49);
        check4("k8_hex", hexValue, 4'h8);
        check1("k8_nokey", nokey, 1'b0);
        check1("k8_kv", key_valid, 1'b1);

        goto_p(64);
        check1("sb_drained", sb.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
